// File: rtl/disp_arbiter.sv
// Round-robin owner selection for the shared 4-digit seven-segment display.
// Enforces a dwell time when contested and a blank gap between owners.
module disp_arbiter #(
    parameter int          DWELL_CYCLES = 50_000_000,
    parameter int          BLANK_CYCLES = 5_000_000,
    parameter int          CNT_W        = 26,
    parameter logic [7:0]  BLANK_PAT    = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic [31:0] src0_digits,
    input  logic        req1,
    input  logic [31:0] src1_digits,
    output logic        gnt0,
    output logic        gnt1,
    output logic [7:0]  in0,
    output logic [7:0]  in1,
    output logic [7:0]  in2,
    output logic [7:0]  in3
);

    localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_MAX = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [31:0]      BLANK4    = {4{BLANK_PAT}};

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        GAP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    // Last-served source; while in SHOW it is also the current owner.
    logic             ptr;

    logic        any_req;
    logic        win;
    logic        own_req;
    logic        oth_req;
    logic        dwell_done;
    logic [31:0] win_digits;
    logic [31:0] own_digits;

    assign any_req    = req0 | req1;
    assign win        = (req0 & req1) ? ~ptr : req1;
    assign win_digits = win ? src1_digits : src0_digits;
    assign own_req    = ptr ? req1 : req0;
    assign oth_req    = ptr ? req0 : req1;
    assign own_digits = ptr ? src1_digits : src0_digits;
    assign dwell_done = (cnt == DWELL_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= IDLE;
            cnt                  <= '0;
            ptr                  <= 1'b1;
            gnt0                 <= 1'b0;
            gnt1                 <= 1'b0;
            {in3, in2, in1, in0} <= BLANK4;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (any_req) begin
                        state                <= SHOW;
                        ptr                  <= win;
                        gnt0                 <= ~win;
                        gnt1                 <= win;
                        {in3, in2, in1, in0} <= win_digits;
                    end else begin
                        gnt0                 <= 1'b0;
                        gnt1                 <= 1'b0;
                        {in3, in2, in1, in0} <= BLANK4;
                    end
                end
                SHOW: begin
                    if (!own_req || (dwell_done && oth_req)) begin
                        state                <= GAP;
                        cnt                  <= '0;
                        gnt0                 <= 1'b0;
                        gnt1                 <= 1'b0;
                        {in3, in2, in1, in0} <= BLANK4;
                    end else begin
                        {in3, in2, in1, in0} <= own_digits;
                        if (!dwell_done) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (cnt == BLANK_MAX) begin
                        cnt <= '0;
                        if (any_req) begin
                            state                <= SHOW;
                            ptr                  <= win;
                            gnt0                 <= ~win;
                            gnt1                 <= win;
                            {in3, in2, in1, in0} <= win_digits;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state                <= IDLE;
                    cnt                  <= '0;
                    gnt0                 <= 1'b0;
                    gnt1                 <= 1'b0;
                    {in3, in2, in1, in0} <= BLANK4;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_disp_arbiter.sv
// Randomized and directed bench for disp_arbiter.
// Compares every cycle against an ownership/timing model.
module tb_disp_arbiter;

    localparam int DWELL = 8;
    localparam int BLANK = 2;
    localparam logic [31:0] BLANK4 = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [31:0] src0_digits = '0;
    logic [31:0] src1_digits = '0;
    logic        gnt0, gnt1;
    logic [7:0]  in0, in1, in2, in3;

    disp_arbiter #(
        .DWELL_CYCLES(DWELL),
        .BLANK_CYCLES(BLANK),
        .CNT_W(4),
        .BLANK_PAT(8'hFF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req0(req0),
        .src0_digits(src0_digits),
        .req1(req1),
        .src1_digits(src1_digits),
        .gnt0(gnt0),
        .gnt1(gnt1),
        .in0(in0),
        .in1(in1),
        .in2(in2),
        .in3(in3)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Model: who owns the display, how long it has shown,
    // how many blank cycles remain, and who was served last.
    int          m_owner = -1;
    int          m_held  = 0;
    int          m_gap   = 0;
    int          m_last  = 1;
    logic [31:0] m_disp  = BLANK4;

    function automatic logic [31:0] digs(input int s);
        return (s == 1) ? src1_digits : src0_digits;
    endfunction

    task automatic pick();
        int w;
        if (req0 || req1) begin
            if (req0 && req1) w = 1 - m_last;
            else              w = req1 ? 1 : 0;
            m_owner = w;
            m_last  = w;
            m_held  = 1;
            m_disp  = digs(w);
        end else begin
            m_owner = -1;
            m_disp  = BLANK4;
        end
    endtask

    task automatic model_edge();
        bit own_req, oth_req;
        if (reset) begin
            m_owner = -1;
            m_gap   = 0;
            m_last  = 1;
            m_disp  = BLANK4;
        end else if (m_gap > 0) begin
            if (m_gap == 1) begin
                m_gap = 0;
                pick();
            end else begin
                m_gap--;
            end
        end else if (m_owner < 0) begin
            pick();
        end else begin
            own_req = (m_owner == 1) ? req1 : req0;
            oth_req = (m_owner == 1) ? req0 : req1;
            if (!own_req || (m_held >= DWELL && oth_req)) begin
                m_owner = -1;
                m_gap   = BLANK;
                m_disp  = BLANK4;
            end else begin
                m_held++;
                m_disp = digs(m_owner);
            end
        end
    endtask

    int cyc = 0;

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("gnt0", 32'(gnt0), 32'(m_owner == 0));
        check("gnt1", 32'(gnt1), 32'(m_owner == 1));
        check("disp", {in3, in2, in1, in0}, m_disp);
        if (gnt0 && gnt1) check("overlap", 32'(gnt0 & gnt1), 32'd0);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        run(n);
        reset = 1'b0;
    endtask

    initial begin
        // Reset values with a pending request
        req0 = 1'b1;
        src0_digits = 32'h1122_3344;
        do_reset(3);
        step();
        check("rst_gnt0", 32'(gnt0), 32'd1);
        check("rst_in0", 32'(in0), 32'h44);
        check("rst_in3", 32'(in3), 32'h11);

        // Contention from cycle 0
        req0 = 1'b0;
        do_reset(1);
        req0 = 1'b1;
        req1 = 1'b1;
        src1_digits = 32'hA1B2_C3D4;
        run(1);
        run(9);
        check("cont_gap9", 32'({gnt1, gnt0}), 32'd0);
        run(2);
        check("cont_gnt1_11", 32'(gnt1), 32'd1);
        run(12);

        // Uncontested hold with changing data
        req1 = 1'b0;
        do_reset(1);
        for (int i = 0; i < 40; i++) begin
            if (i % 5 == 0) src0_digits = $urandom;
            step();
        end
        // Saturated dwell: contender forces an immediate gap
        req1 = 1'b1;
        run(1);
        req1 = 1'b0;
        run(4);

        // Early release, without then with the other requester
        for (int v = 0; v < 2; v++) begin
            req0 = 1'b0;
            req1 = 1'b0;
            do_reset(1);
            req0 = 1'b1;
            run(4);
            req0 = 1'b0;
            req1 = (v == 1);
            run(8);
        end

        // Late requester dropping during gap
        for (int v = 0; v < 2; v++) begin
            req1 = 1'b0;
            do_reset(1);
            req0 = 1'b1;
            run(20);
            req1 = 1'b1;
            run(1);
            req1 = 1'b0;
            req0 = (v == 1);
            run(6);
        end

        // Reset during SHOW of source 1
        req0 = 1'b0;
        req1 = 1'b1;
        do_reset(1);
        run(5);
        reset = 1'b1;
        step();
        check("mid_rst_gnt1", 32'(gnt1), 32'd0);
        reset = 1'b0;
        req0 = 1'b1;
        step();
        check("mid_rst_win0", 32'(gnt0), 32'd1);
        run(20);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(15) == 0) req0 = ~req0;
            if ($urandom_range(15) == 0) req1 = ~req1;
            if ($urandom_range(3) == 0) src0_digits = $urandom;
            if ($urandom_range(3) == 0) src1_digits = $urandom;
            reset = ($urandom_range(499) == 0);
            step();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
